multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 opcode  input  7  instruction register bits [6:0], valid from DECODE onward.
REQ-005 zero  input  1  ALU zero flag, sampled in BRANCH.
REQ-006 mem_ready  input  1  memory handshake; access completes in a cycle where mem_ready=1 and the request strobe is high.
REQ-007 alu_op0, alu_op1  output  1 each  ALUOp to the ALU function decoder: 00=ADD, 01=SUB, 10=decode funct.
REQ-008 alu_src_a  output  2  00=PC, 01=rs1, 10=old PC.
REQ-009 alu_src_b  output  2  00=rs2, 01=imm, 10=constant 4.
REQ-010 iord, mem_read, mem_write  output  1 each  address select (0=PC, 1=ALUOut) and memory strobes.
REQ-011 ir_write, pc_write, reg_write, mem_to_reg  output  1 each  register-file and IR/PC write enables, plus the writeback select (1=MDR).
REQ-012 illegal  output  1  sticky flag for an unsupported opcode.
REQ-013 retired  output  32  count of completed instructions.
REQ-014 state_dbg  output  4  current state encoding.

Function
REQ-015 States SHALL be FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, WB_ALU, BRANCH, TRAP.
REQ-016 All outputs SHALL be decoded from state only; the exceptions are ir_write, pc_write (FETCH) and the BRANCH pc_write, which are additionally gated as stated below.
REQ-017 In FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=10, ALUOp=00.
REQ-018 In FETCH: ir_write=pc_write=mem_ready, and the state SHALL advance to DECODE only when mem_ready=1; otherwise it holds with all strobes stable.
REQ-019 In DECODE: alu_src_a=10, alu_src_b=01, ALUOp=00 (branch target); there are no write strobes.
REQ-020 DECODE next-state by opcode:
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 0000011 and 0100011 -> MEM_ADDR
- 1100011 -> BRANCH
- any other value -> TRAP
REQ-021 In EXEC_R: alu_src_a=01, alu_src_b=00, ALUOp=10; next state is WB_ALU.
REQ-022 In EXEC_I: alu_src_a=01, alu_src_b=01, ALUOp=10; next state is WB_ALU.
REQ-023 In MEM_ADDR: alu_src_a=01, alu_src_b=01, ALUOp=00; next state is MEM_RD if the opcode is a load, else MEM_WR.
REQ-024 In MEM_RD and MEM_WR: iord=1 and mem_read or mem_write=1 respectively, held until mem_ready=1.
REQ-025 On mem_ready, MEM_RD SHALL go to WB_MEM and MEM_WR SHALL go to FETCH.
REQ-026 In WB_MEM: reg_write=1, mem_to_reg=1.
REQ-027 In WB_ALU: reg_write=1, mem_to_reg=0.
REQ-028 WB_MEM and WB_ALU SHALL both go to FETCH.
REQ-029 In BRANCH: alu_src_a=01, alu_src_b=00, ALUOp=01, pc_write=zero; next state is FETCH.
REQ-030 TRAP SHALL assert illegal=1 with all strobes 0, and SHALL remain in TRAP until reset.
REQ-031 retired SHALL increment by 1 (wrapping at 2^32-1 -> 0) on each transition into FETCH from WB_MEM, WB_ALU, MEM_WR or BRANCH.
REQ-032 mem_read and mem_write SHALL never be high in the same cycle.
REQ-033 reg_write and pc_write SHALL never be high in the same cycle.

Reset
REQ-034 When reset=1 at a rising edge, the block SHALL set state=FETCH, retired=0 and illegal=0, overriding any other condition, including mid-wait in MEM_RD/MEM_WR and TRAP.
REQ-035 While reset=1, all write and memory strobes SHALL be forced to 0.
REQ-036 The first FETCH after reset deassertion SHALL issue mem_read in the first cycle with reset=0.

Structure
REQ-037 The state enumeration, opcode constants and ALUOp encodings SHALL live in the shared package riscv_pkg.
REQ-038 The state register/next-state logic and the retired counter SHALL be in this module.
REQ-039 Output decoding SHALL be one sub-module, mc_output_decode (state and mem_ready in, strobes out).
REQ-040 The ALU function decoder SHALL be instantiated by the parent, not inside this block.

Verification
REQ-041 Bench: R-type 0110011 with mem_ready=1 in the first FETCH cycle -> states FETCH, DECODE, EXEC_R, WB_ALU, FETCH; ALUOp=10 in EXEC_R; one reg_write pulse; retired 0->1.
REQ-042 Bench: load 0000011 with mem_ready held low 3 cycles in MEM_RD -> mem_read and iord held for 4 cycles; WB_MEM has mem_to_reg=1; 5 states plus 3 waits to retire.
REQ-043 Bench: BEQ with zero=1 -> pc_write=1 in BRANCH; with zero=0 -> pc_write=0; retired increments in both cases.
REQ-044 Bench: opcode 1111111 -> TRAP and illegal=1, stuck for 10 cycles; then reset -> FETCH, illegal=0, retired=0.
REQ-045 Bench: reset asserted in MEM_WR with mem_ready=0 -> next state FETCH, no mem_write while reset=1.
REQ-046 Bench: retired preloaded to 0xFFFFFFFF, one store -> retired=0; mem_read and mem_write never coincide (assertion).

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V controller: state encoding,
// major opcodes, ALUOp encodings, ALU operand selects and the DECODE dispatch.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_MEM   = 4'd7,
    WB_ALU   = 4'd8,
    BRANCH   = 4'd9,
    TRAP     = 4'd10
  } mc_state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;

  // Successor of DECODE for a given major opcode; anything unsupported traps.
  function automatic mc_state_t decode_next(input logic [6:0] opcode);
    case (opcode)
      OP_RTYPE:           return EXEC_R;
      OP_ITYPE:           return EXEC_I;
      OP_LOAD, OP_STORE:  return MEM_ADDR;
      OP_BRANCH:          return BRANCH;
      default:            return TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore-style control strobe decode for the multicycle controller.
// Only the FETCH IR/PC writes (mem_ready) and the BRANCH PC write (zero)
// depend on anything other than the current state.
module mc_output_decode
  import riscv_pkg::*;
(
  input  mc_state_t  state,
  input  logic       mem_ready,
  input  logic       zero,
  output alu_op_t    alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_to_reg
);

  // Per-state datapath selects and strobes; unlisted states leave all strobes low.
  always_comb begin
    alu_op     = ALUOP_ADD;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b = SRC_B_FOUR;
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
      end
      EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      WB_ALU: begin
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALUOP_SUB;
        pc_write  = zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main controller: state register, next-state logic,
// sticky illegal-opcode flag and retired-instruction counter.
module multicycle_control
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        alu_op0,
  output logic        alu_op1,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [31:0] retired,
  output logic [3:0]  state_dbg
);

  mc_state_t   state;
  mc_state_t   decode_tgt;
  logic [31:0] retired_q;
  logic        illegal_q;

  alu_op_t     alu_op;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_ir_write;
  logic        dec_pc_write;
  logic        dec_reg_write;

  assign decode_tgt = decode_next(opcode);

  // State sequencing, retire counting on every return to FETCH, illegal latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          state <= decode_tgt;
          if (decode_tgt == TRAP) illegal_q <= 1'b1;
        end
        EXEC_R,
        EXEC_I:   state <= WB_ALU;
        MEM_ADDR: state <= (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
        MEM_RD:   if (mem_ready) state <= WB_MEM;
        MEM_WR: begin
          if (mem_ready) begin
            state     <= FETCH;
            retired_q <= retired_q + 32'd1;
          end
        end
        WB_MEM,
        WB_ALU,
        BRANCH: begin
          state     <= FETCH;
          retired_q <= retired_q + 32'd1;
        end
        TRAP:     state <= TRAP;
        default:  state <= FETCH;
      endcase
    end
  end

  mc_output_decode u_decode (
    .state      (state),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .iord       (iord),
    .mem_read   (dec_mem_read),
    .mem_write  (dec_mem_write),
    .ir_write   (dec_ir_write),
    .pc_write   (dec_pc_write),
    .reg_write  (dec_reg_write),
    .mem_to_reg (mem_to_reg)
  );

  // Reset suppresses every write/memory strobe combinationally, so the FETCH
  // read only appears in the first cycle after reset drops.
  assign mem_read  = dec_mem_read  & ~reset;
  assign mem_write = dec_mem_write & ~reset;
  assign ir_write  = dec_ir_write  & ~reset;
  assign pc_write  = dec_pc_write  & ~reset;
  assign reg_write = dec_reg_write & ~reset;

  assign alu_op1   = alu_op[1];
  assign alu_op0   = alu_op[0];
  assign illegal   = illegal_q;
  assign retired   = retired_q;
  assign state_dbg = state;

endmodule
